// File: rtl/histo_pkg.sv
// Shared types and elaboration helpers for the histogram top-N engine.
package histo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SCAN    = 2'd2,
        ST_DONE    = 2'd3
    } histo_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned index_width(input int unsigned value);
        return (log2_ceil(value) > 0) ? log2_ceil(value) : 1;
    endfunction

endpackage

// File: rtl/histo_topn_sort.sv
// Descending TOP_N insertion sorter; strict compare keeps the earlier bin ahead on ties.
module histo_topn_sort
    import histo_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 4,
    parameter int unsigned SUM_SIZE  = 10,
    parameter int unsigned TOP_N     = 3
) (
    input  logic                 clk200,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic [SUM_SIZE-1:0]  in_count,
    output logic [DATA_SIZE-1:0] slot_data  [TOP_N],
    output logic [SUM_SIZE-1:0]  slot_count [TOP_N]
);

    logic [TOP_N-1:0] gt_c;

    // A slot is displaced when the candidate strictly beats its count.
    always_comb begin
        gt_c = '0;
        for (int unsigned i = 0; i < TOP_N; i++) begin
            gt_c[i] = in_valid && (in_count != '0) && (in_count > slot_count[i]);
        end
    end

    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < TOP_N; i++) begin
                slot_data[i]  <= '0;
                slot_count[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < TOP_N; i++) begin
                slot_data[i]  <= '0;
                slot_count[i] <= '0;
            end
        end else begin
            if (gt_c[0]) begin
                slot_data[0]  <= in_data;
                slot_count[0] <= in_count;
            end
            // Slots below the insertion point shift down by one.
            for (int unsigned i = 1; i < TOP_N; i++) begin
                if (gt_c[i]) begin
                    if (gt_c[i-1]) begin
                        slot_data[i]  <= slot_data[i-1];
                        slot_count[i] <= slot_count[i-1];
                    end else begin
                        slot_data[i]  <= in_data;
                        slot_count[i] <= in_count;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/histogram_topn_engine.sv
// Multi-channel histogram with a ranked top-N scan of the merged bins.
// Define HISTO_SATURATE_EN to make bin counters saturate and drive sat_flag.
module histogram_topn_engine
    import histo_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 4,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned COUNT_SIZE = 8,
    parameter int unsigned TOP_N      = 3,
    localparam int unsigned SUM_SIZE  = COUNT_SIZE + log2_ceil(NUM_CH)
) (
    input  logic                          clk200,
    input  logic                          rstn,
    input  logic                          collect,
    input  logic                          valid,
    input  logic [DATA_SIZE-1:0]          data,
    output logic                          busy,
    output logic                          result_valid,
    output logic [TOP_N*DATA_SIZE-1:0]    top_data,
    output logic [TOP_N*SUM_SIZE-1:0]     top_count,
    output logic                          sat_flag
);

    localparam int unsigned DATA_NUM = 2 ** DATA_SIZE;
    localparam int unsigned PTR_W    = index_width(NUM_CH);
    localparam int unsigned CNT_W    = DATA_SIZE + 2;
    localparam logic [COUNT_SIZE-1:0] BIN_MAX = '1;

    histo_state_e state, state_next;
    logic busy_d, rv_d, start_c, hit_c;

    logic [PTR_W-1:0]      ptr;
    logic [COUNT_SIZE-1:0] hist [NUM_CH][DATA_NUM];
    logic                  sat_q;

    logic [CNT_W-1:0]     scan_cnt;
    logic [DATA_SIZE-1:0] scan_addr;
    logic [SUM_SIZE-1:0]  sum_c, sum_q;
    logic [DATA_SIZE-1:0] sum_bin;
    logic                 sum_vld;

    logic [DATA_SIZE-1:0] slot_data  [TOP_N];
    logic [SUM_SIZE-1:0]  slot_count [TOP_N];

    assign scan_addr = scan_cnt[DATA_SIZE-1:0];
    assign hit_c     = (state == ST_COLLECT) && collect && valid;

    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            busy         <= busy_d;
            result_valid <= rv_d;
        end
    end

    always_comb begin
        state_next = state;
        busy_d     = 1'b0;
        rv_d       = 1'b0;
        start_c    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (collect) begin
                    state_next = ST_COLLECT;
                    start_c    = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (!collect) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Address sweep, sum register and sorter stage drain by count DATA_NUM+2.
                if (scan_cnt == CNT_W'(DATA_NUM + 2)) begin
                    state_next = ST_DONE;
                    rv_d       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        busy_d = (state_next == ST_COLLECT) || (state_next == ST_SCAN);
    end

    // Round-robin sample accumulation into per-channel bins.
    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned b = 0; b < DATA_NUM; b++) begin
                    hist[c][b] <= '0;
                end
            end
            ptr   <= '0;
            sat_q <= 1'b0;
        end else if (start_c) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned b = 0; b < DATA_NUM; b++) begin
                    hist[c][b] <= '0;
                end
            end
            ptr   <= '0;
            sat_q <= 1'b0;
        end else if (hit_c) begin
`ifdef HISTO_SATURATE_EN
            if (hist[ptr][data] == BIN_MAX) begin
                sat_q <= 1'b1;
            end else begin
                hist[ptr][data] <= hist[ptr][data] + COUNT_SIZE'(1);
            end
`else
            hist[ptr][data] <= hist[ptr][data] + COUNT_SIZE'(1);
`endif
            ptr <= (ptr == PTR_W'(NUM_CH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

`ifdef HISTO_SATURATE_EN
    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    always_comb begin
        sum_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sum_c = sum_c + SUM_SIZE'(hist[c][scan_addr]);
        end
    end

    // Scan sequencer and registered cross-channel sum.
    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            scan_cnt <= '0;
            sum_q    <= '0;
            sum_bin  <= '0;
            sum_vld  <= 1'b0;
        end else begin
            scan_cnt <= (state == ST_SCAN) ? scan_cnt + CNT_W'(1) : '0;
            sum_q    <= sum_c;
            sum_bin  <= scan_addr;
            sum_vld  <= (state == ST_SCAN) && (scan_cnt < CNT_W'(DATA_NUM));
        end
    end

    histo_topn_sort #(
        .DATA_SIZE (DATA_SIZE),
        .SUM_SIZE  (SUM_SIZE),
        .TOP_N     (TOP_N)
    ) u_sort (
        .clk200     (clk200),
        .rstn       (rstn),
        .clr        (start_c),
        .in_valid   (sum_vld),
        .in_data    (sum_bin),
        .in_count   (sum_q),
        .slot_data  (slot_data),
        .slot_count (slot_count)
    );

    always_comb begin
        top_data  = '0;
        top_count = '0;
        for (int unsigned i = 0; i < TOP_N; i++) begin
            top_data[i*DATA_SIZE +: DATA_SIZE] = slot_data[i];
            top_count[i*SUM_SIZE +: SUM_SIZE]  = slot_count[i];
        end
    end

endmodule

// File: doc/histogram_topn_engine.md
HISTOGRAM_TOPN_ENGINE -- requirements
Module: histogram_topn_engine

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 4, giving sample width; DATA_NUM = 2**DATA_SIZE bins.
REQ-002 SHALL have parameter NUM_CH, default 4, giving the number of interleaved histogram channels (power of two, >=1).
REQ-003 SHALL have parameter COUNT_SIZE, default 8, giving the per-channel bin counter width.
REQ-004 SHALL have parameter TOP_N, default 3, giving the number of ranked results (1..DATA_NUM).
REQ-005 SHALL have port clk200, input, 1: sole clock, all logic on the rising edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port collect, input, 1: level; high means accumulate samples.
REQ-008 SHALL have ports valid, input, 1 and data, input, DATA_SIZE: sample strobe and value.
REQ-009 SHALL have port busy, output, 1: high in states COLLECT and SCAN.
REQ-010 SHALL have port result_valid, output, 1: single-cycle pulse when ranking is complete.
REQ-011 SHALL have ports top_data, output, TOP_N*DATA_SIZE and top_count, output, TOP_N*SUM_SIZE, where SUM_SIZE = COUNT_SIZE+log2(NUM_CH); slot 0 occupies the LSBs and ranks highest.
REQ-012 SHALL have port sat_flag, output, 1: sticky indication that a bin counter saturated this collection.

Function
REQ-013 SHALL implement states IDLE, COLLECT, SCAN, DONE.
REQ-014 SHALL, in IDLE or DONE with collect=1, enter COLLECT, zero all histograms, top_data, top_count and sat_flag, and set the round-robin pointer to 0 in that same edge.
REQ-015 SHALL, in COLLECT, count each sample with valid=1 and collect=1 into channel[pointer] bin[data], then advance the pointer modulo NUM_CH.
REQ-016 SHALL ignore valid whenever collect=0 or the state is not COLLECT.
REQ-017 SHALL, in COLLECT with collect=0, enter SCAN.
REQ-018 SHALL, in SCAN, step a bin address 0..DATA_NUM-1 at one per cycle, register the sum across all channels (SUM_SIZE bits, no overflow possible), and offer {bin,sum} to the sorter the following cycle.
REQ-019 SHALL insert a candidate into the sorter only when sum>0 and sum is strictly greater than the count in some slot; equal counts keep the earlier (lower) bin ahead.
REQ-020 SHALL leave unfilled slots at data 0 and count 0.
REQ-021 SHALL pulse result_valid and enter DONE exactly DATA_NUM+3 cycles after the edge that entered SCAN.
REQ-022 SHALL hold top_data, top_count and sat_flag stable in DONE until the next COLLECT entry.
REQ-023 SHALL ignore collect while in SCAN; collect still high in DONE starts a new collection one cycle after result_valid.

Reset
REQ-024 SHALL, on rstn low at any time including mid-SCAN, force state IDLE, the pointer to 0, all histograms, top_data, top_count, busy, result_valid and sat_flag to 0.

Configuration
REQ-025 SHALL, with macro HISTO_SATURATE_EN defined, hold a bin counter at 2**COUNT_SIZE-1 on further hits and set sat_flag.
REQ-026 SHALL, without HISTO_SATURATE_EN, let bin counters wrap modulo 2**COUNT_SIZE and tie sat_flag to 0.

Structure
REQ-027 SHALL take the state enum and a clog2-style width helper from shared package histo_pkg.
REQ-028 SHALL place the TOP_N insertion sorter in sub-module histo_topn_sort (inputs clr, in_valid, in_data, in_count; outputs slot arrays).

Verification (DATA_SIZE=4, NUM_CH=4, COUNT_SIZE=8, TOP_N=3)
REQ-029 SHALL check 10x value 5, 7x value 2, 3x value 9, then collect low -> slots (5,10),(2,7),(9,3); result_valid exactly 19 cycles after SCAN entry.
REQ-030 SHALL check 4x value 3 and 4x value 1 -> slots (1,4),(3,4),(0,0).
REQ-031 SHALL check 1100 back-to-back samples of value 7 -> with HISTO_SATURATE_EN: (7,1020), sat_flag=1; without it: (7,76), sat_flag=0.
REQ-032 SHALL check rstn asserted 5 cycles into SCAN -> all outputs 0, state IDLE, no result_valid.
REQ-033 SHALL check collect re-raised during SCAN -> result unaffected and result_valid on schedule; collect held high through DONE -> top outputs cleared on the next edge, busy=1.
REQ-034 SHALL check valid=1 with collect=0 in IDLE, and an empty collection -> no bins counted; all slots (0,0).
